// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 scan-code register loader.
//   - Scan-code constants for break, extended prefix and Enter.
//   - Frame receiver state encoding.
//   - Scan-code to ASCII lookup. It is compiled only when PS2_REG_LOADER_ASCII_EN
//     is defined.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_ENTER = 8'h5A;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

`ifdef PS2_REG_LOADER_ASCII_EN
  typedef struct packed {
    logic       hit;
    logic [7:0] code;
  } ps2_ascii_t;

  // Covers the digits 0-9, the letters A-F and space.
  // Any other scan code is reported as a miss.
  function automatic ps2_ascii_t ps2_to_ascii(input logic [7:0] sc);
    ps2_ascii_t r;
    r.hit  = 1'b1;
    r.code = 8'h00;
    case (sc)
      8'h45: r.code = 8'h30;
      8'h16: r.code = 8'h31;
      8'h1E: r.code = 8'h32;
      8'h26: r.code = 8'h33;
      8'h25: r.code = 8'h34;
      8'h2E: r.code = 8'h35;
      8'h36: r.code = 8'h36;
      8'h3D: r.code = 8'h37;
      8'h3E: r.code = 8'h38;
      8'h46: r.code = 8'h39;
      8'h1C: r.code = 8'h41;
      8'h32: r.code = 8'h42;
      8'h21: r.code = 8'h43;
      8'h23: r.code = 8'h44;
      8'h24: r.code = 8'h45;
      8'h2B: r.code = 8'h46;
      8'h29: r.code = 8'h20;
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction
`endif

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: receives PS/2 device-to-host frames.
// The raw PS/2 lines are synchronised into clk and the falling edges of
// ps2_clk are detected. The receiver then walks through the start bit, eight
// data bits (LSB first), the parity bit and the stop bit. Parity must be odd.
// If ps2_clk stops part-way through a frame, the frame is abandoned.
// Ports:
//   clk, rst    system clock and synchronous active-high reset
//   ps2_clk     raw PS/2 clock (asynchronous)
//   ps2_data    raw PS/2 data (asynchronous)
//   rx_byte     last good byte; holds between frames
//   byte_valid  one-cycle pulse when rx_byte is updated
//   frame_err   one-cycle pulse on a start, parity or stop error, or a timeout
//   busy        high while a frame is in progress
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  logic [2:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       data_sync_q, data_sync_d;
  ps2_state_t       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  logic fall;
  logic bit_in;

  // Bit 2 of the clock synchroniser is a delayed copy used only for edge compare.
  assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
  assign bit_in = data_sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q   <= 3'b111;
      data_sync_q  <= 2'b11;
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      tmo_cnt_q    <= '0;
      byte_q       <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tmo_cnt_q    <= tmo_cnt_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    clk_sync_d   = {clk_sync_q[1:0], ps2_clk};
    data_sync_d  = {data_sync_q[0], ps2_data};
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    // The watchdog only runs between edges of a frame that is in progress.
    if (state_q == IDLE || fall) begin
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end

    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!bit_in) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d = {bit_in, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        PARITY: begin
          parity_d = bit_in;
          state_d  = STOP;
        end
        STOP: begin
          if (bit_in && (^{parity_q, shift_q})) begin
            byte_d       = shift_q;
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_cnt_q == CNT_MAX) begin
      frame_err_d = 1'b1;
      state_d     = IDLE;
    end
  end

  assign rx_byte    = byte_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: rtl/ps2_reg_loader.sv
// ps2_reg_loader: loads PS/2 make codes into successive register-file slots.
// Frames are received by ps2_frame_rx. Break (F0) and extended (E0) sequences
// are then filtered out. Enter (5A) rewinds the slot pointer to 0. Every other
// make code is written to the next slot, and the pointer wraps after slot
// NUM_SLOTS-1.
// Optional feature (macro PS2_REG_LOADER_ASCII_EN): codes that pass the filter
// are translated to ASCII. Unmapped codes are dropped.
// Ports:
//   clk, rst   system clock and synchronous active-high reset
//   ps2_clk    raw PS/2 clock (asynchronous)
//   ps2_data   raw PS/2 data (asynchronous)
//   wr_en      one-cycle register-file write strobe
//   wr_addr    slot address; holds between writes
//   wr_data    byte written; holds between writes
//   frame_err  one-cycle pulse on any frame error or timeout
//   busy       high while a frame is in progress
module ps2_reg_loader
  import ps2_pkg::*;
#(
  parameter int NUM_SLOTS   = 6,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       wr_en,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [3:0] PTR_LAST = 4'(NUM_SLOTS - 1);

  logic [7:0] rx_byte;
  logic       byte_valid;

  logic [3:0] ptr_q, ptr_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic       wr_en_q, wr_en_d;
  logic [3:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;

`ifdef PS2_REG_LOADER_ASCII_EN
  ps2_ascii_t lut;
`endif

  ps2_frame_rx #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= 4'd0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 4'd0;
      wr_data_q <= 8'h00;
    end else begin
      ptr_q     <= ptr_d;
      brk_q     <= brk_d;
      ext_q     <= ext_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // The filter order matters. A pending break swallows the next code, even
  // Enter. Enter rewinds the pointer even after an E0 prefix.
  always_comb begin
    ptr_d     = ptr_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef PS2_REG_LOADER_ASCII_EN
    lut = ps2_to_ascii(rx_byte);
`endif

    if (byte_valid) begin
      if (rx_byte == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_BREAK) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (rx_byte == PS2_ENTER) begin
        ptr_d = 4'd0;
        ext_d = 1'b0;
      end else if (ext_q) begin
        ext_d = 1'b0;
      end else begin
`ifdef PS2_REG_LOADER_ASCII_EN
        if (lut.hit) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = lut.code;
          ptr_d     = (ptr_q == PTR_LAST) ? 4'd0 : ptr_q + 4'd1;
        end
`else
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q;
        wr_data_d = rx_byte;
        ptr_d     = (ptr_q == PTR_LAST) ? 4'd0 : ptr_q + 4'd1;
`endif
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_ps2_reg_loader.sv
// tb_ps2_reg_loader: self-checking bench for ps2_reg_loader.
// A behavioural model predicts the register writes and the frame errors for
// each frame that is sent. Observed writes are collected on falling clk edges.
// Each test task then compares the observed queue against the predicted one.
module tb_ps2_reg_loader;

  localparam int NSLOTS = 6;
  localparam int TMO    = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int half = 8;
  int lat_cnt = 0;

  logic [11:0] obs_q[$];
  logic [11:0] exp_q[$];
  int err_seen = 0;
  int exp_err = 0;

  int m_ptr = 0;
  bit m_brk = 1'b0;
  bit m_ext = 1'b0;

  logic [7:0] pool[12] = '{8'h16, 8'h1E, 8'h26, 8'h45, 8'h1C, 8'h29,
                           8'hF0, 8'hE0, 8'h5A, 8'h75, 8'h2B, 8'h3D};

  ps2_reg_loader #(
    .NUM_SLOTS  (NSLOTS),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Collect every write strobe and every error pulse.
  always @(negedge clk) begin
    if (wr_en) obs_q.push_back({wr_addr, wr_data});
    if (frame_err) err_seen++;
  end

  // Returns the stored value for a scan code, or -1 if the code is not stored.
  function automatic int stored_value(input logic [7:0] b);
`ifdef PS2_REG_LOADER_ASCII_EN
    case (b)
      8'h45: return 'h30; 8'h16: return 'h31; 8'h1E: return 'h32;
      8'h26: return 'h33; 8'h25: return 'h34; 8'h2E: return 'h35;
      8'h36: return 'h36; 8'h3D: return 'h37; 8'h3E: return 'h38;
      8'h46: return 'h39; 8'h1C: return 'h41; 8'h32: return 'h42;
      8'h21: return 'h43; 8'h23: return 'h44; 8'h24: return 'h45;
      8'h2B: return 'h46; 8'h29: return 'h20;
      default: return -1;
    endcase
`else
    return int'(b);
`endif
  endfunction

  // Reference behaviour of the code filter and the slot pointer.
  task automatic model_byte(input logic [7:0] b);
    int v;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (m_brk) begin m_brk = 1'b0; m_ext = 1'b0; end
    else if (b == 8'h5A) begin m_ptr = 0; m_ext = 1'b0; end
    else if (m_ext) m_ext = 1'b0;
    else begin
      v = stored_value(b);
      if (v >= 0) begin
        exp_q.push_back({4'(m_ptr), 8'(v)});
        m_ptr = (m_ptr + 1) % NSLOTS;
      end
    end
  endtask

  task automatic drive_bit(input logic v);
    @(posedge clk); #1 ps2_data = v;
    repeat (half - 1) @(posedge clk);
    #1 ps2_clk = 1'b0;
    for (int i = 1; i <= half; i++) begin
      @(negedge clk);
      if (wr_en && lat_cnt == 0) lat_cnt = i;
    end
    @(posedge clk); #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~^b;
    if (bad_par) par = ~par;
    if (bad_par || bad_stop) exp_err++;
    else model_byte(b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(par);
    lat_cnt = 0;
    drive_bit(!bad_stop);
    @(posedge clk); #1 ps2_data = 1'b1;
    repeat (2 * half) @(posedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({wr_en, wr_addr, wr_data, frame_err, busy} !== 15'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got en=%b addr=%0d data=%h err=%b busy=%b, expected all 0",
               wr_en, wr_addr, wr_data, frame_err, busy);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    obs_q.delete(); err_seen = 0;
  endtask

  task automatic test_single_write;
    send_frame(8'h16, 1'b0, 1'b0);
    checks++;
    if (lat_cnt !== 5) begin
      errors++;
      $display("[TB] FAIL single_latency: got wr_en at sample %0d after stop edge, expected 5", lat_cnt);
    end
    repeat (12) @(posedge clk);
    checks++;
    if (obs_q.size() !== 1) begin
      errors++;
      $display("[TB] FAIL single_count: got %0d writes, expected 1", obs_q.size());
    end
    if (obs_q.size() >= 1) begin
      checks++;
`ifdef PS2_REG_LOADER_ASCII_EN
      if (obs_q[0] !== 12'h031) begin
`else
      if (obs_q[0] !== 12'h016) begin
`endif
        errors++;
        $display("[TB] FAIL single_write: got addr=%0d data=%h", obs_q[0][11:8], obs_q[0][7:0]);
      end
    end
    checks++;
    if (err_seen !== 0) begin
      errors++;
      $display("[TB] FAIL single_err: got %0d error pulses, expected 0", err_seen);
    end
    obs_q.delete(); exp_q.delete(); err_seen = 0; exp_err = 0;
  endtask

  task automatic test_break_filter;
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h16, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    send_frame(8'h1E, 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL break_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL break_write%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                 i, obs_q[i][11:8], obs_q[i][7:0], exp_q[i][11:8], exp_q[i][7:0]);
      end
    end
    checks++;
    if (err_seen !== exp_err) begin
      errors++;
      $display("[TB] FAIL break_err: got %0d error pulses, expected %0d", err_seen, exp_err);
    end
    obs_q.delete(); exp_q.delete(); err_seen = 0; exp_err = 0;
  endtask

  task automatic test_wrap_enter;
    logic [7:0] codes[7] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D};
    foreach (codes[i]) send_frame(codes[i], 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0);
    send_frame(8'h16, 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL wrap_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL wrap_write%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                 i, obs_q[i][11:8], obs_q[i][7:0], exp_q[i][11:8], exp_q[i][7:0]);
      end
    end
    checks++;
    if (err_seen !== exp_err) begin
      errors++;
      $display("[TB] FAIL wrap_err: got %0d error pulses, expected %0d", err_seen, exp_err);
    end
    obs_q.delete(); exp_q.delete(); err_seen = 0; exp_err = 0;
  endtask

  task automatic test_frame_errors;
    send_frame(8'h16, 1'b1, 1'b0);
    send_frame(8'h16, 1'b0, 1'b1);
    // A lone clock pulse with data high is a bad start bit.
    exp_err++;
    drive_bit(1'b1);
    repeat (2 * half) @(posedge clk);
    send_frame(8'h1E, 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL errs_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL errs_write%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                 i, obs_q[i][11:8], obs_q[i][7:0], exp_q[i][11:8], exp_q[i][7:0]);
      end
    end
    checks++;
    if (err_seen !== exp_err) begin
      errors++;
      $display("[TB] FAIL errs_err: got %0d error pulses, expected %0d", err_seen, exp_err);
    end
    obs_q.delete(); exp_q.delete(); err_seen = 0; exp_err = 0;
  endtask

  task automatic test_timeout;
    logic [7:0] b;
    b = 8'h16;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tmo_busy: got busy=%b mid-frame, expected 1", busy);
    end
    repeat (TMO - 60) @(posedge clk);
    checks++;
    if (err_seen !== 0) begin
      errors++;
      $display("[TB] FAIL tmo_early: got %0d error pulses before timeout, expected 0", err_seen);
    end
    repeat (100) @(posedge clk);
    @(negedge clk);
    checks++;
    if (err_seen !== 1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tmo_fire: got %0d error pulses busy=%b, expected 1 and busy=0", err_seen, busy);
    end
    err_seen = 0;
    send_frame(8'h16, 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL tmo_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL tmo_write%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                 i, obs_q[i][11:8], obs_q[i][7:0], exp_q[i][11:8], exp_q[i][7:0]);
      end
    end
    checks++;
    if (err_seen !== exp_err) begin
      errors++;
      $display("[TB] FAIL tmo_err: got %0d error pulses, expected %0d", err_seen, exp_err);
    end
    obs_q.delete(); exp_q.delete(); err_seen = 0; exp_err = 0;
  endtask

  task automatic test_reset_midframe;
    logic [7:0] b;
    b = 8'h1E;
    drive_bit(1'b0);
    for (int i = 0; i < 6; i++) drive_bit(b[i]);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({wr_en, wr_addr, wr_data, frame_err, busy} !== 15'h0) begin
      errors++;
      $display("[TB] FAIL midrst_outputs: got en=%b addr=%0d data=%h err=%b busy=%b, expected all 0",
               wr_en, wr_addr, wr_data, frame_err, busy);
    end
    m_ptr = 0; m_brk = 1'b0; m_ext = 1'b0;
    repeat (4 * half) @(posedge clk);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    send_frame(8'h16, 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL midrst_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL midrst_write%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                 i, obs_q[i][11:8], obs_q[i][7:0], exp_q[i][11:8], exp_q[i][7:0]);
      end
    end
    checks++;
    if (err_seen !== exp_err) begin
      errors++;
      $display("[TB] FAIL midrst_err: got %0d error pulses, expected %0d", err_seen, exp_err);
    end
    obs_q.delete(); exp_q.delete(); err_seen = 0; exp_err = 0;
  endtask

  task automatic test_random;
    logic [7:0] b;
    int k;
    for (int n = 0; n < 40; n++) begin
      half = $urandom_range(6, 10);
      k = $urandom_range(0, 9);
      b = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      send_frame(b, k == 0, k == 1);
    end
    half = 8;
    repeat (12) @(posedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL rand_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL rand_write%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                 i, obs_q[i][11:8], obs_q[i][7:0], exp_q[i][11:8], exp_q[i][7:0]);
      end
    end
    checks++;
    if (err_seen !== exp_err) begin
      errors++;
      $display("[TB] FAIL rand_err: got %0d error pulses, expected %0d", err_seen, exp_err);
    end
    obs_q.delete(); exp_q.delete(); err_seen = 0; exp_err = 0;
  endtask

  initial begin
    $display("[TB] starting ps2_reg_loader bench");
    test_reset();
    test_single_write();
    test_break_filter();
    test_wrap_enter();
    test_frame_errors();
    test_timeout();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
